// File: rtl/axi_lite_pkg.sv
// ---------------------------------------------------------------------------
// axi_lite_pkg
// Shared AXI-Lite definitions for the register-slave family.
//   RSP_*   : two-bit AXI response codes carried on RRESP/BRESP
//   state_t : read-slave FSM states (IDLE, WAIT, RESP)
// ---------------------------------------------------------------------------
package axi_lite_pkg;

    localparam logic [1:0] RSP_OKAY   = 2'b00;
    localparam logic [1:0] RSP_EXOKAY = 2'b01;
    localparam logic [1:0] RSP_SLVERR = 2'b10;
    localparam logic [1:0] RSP_DECERR = 2'b11;

    // IDLE : ready to accept an AR beat
    // WAIT : backend read in flight, counting down its fixed latency
    // RESP : response registered, presenting it on the R channel
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/axi_lite_read_slave.sv
// ---------------------------------------------------------------------------
// axi_lite_read_slave
// AXI-Lite read-only slave that maps a window of NUM_REGS 32-bit words at
// BASE_ADDR onto a simple fixed-latency backend read port. One transaction
// is outstanding at a time.
//
// Parameters
//   ADDR_WIDTH : byte-address width of s_axi_araddr
//   BASE_ADDR  : byte address of word index 0 (word aligned)
//   NUM_REGS   : number of decoded words (power of two, 2..256)
//   RD_LATENCY : cycles from rd_en to valid rd_data (1..15)
//
// Ports
//   clk, reset                  : clock, synchronous active-high reset
//   s_axi_arvalid/arready/araddr: AR channel
//   s_axi_rvalid/rready         : R channel handshake
//   s_axi_rdata/rresp           : R channel payload
//   rd_en, rd_index             : backend read strobe and word index
//   rd_data                     : backend data, RD_LATENCY cycles after rd_en
//   err_count                   : saturating count of error responses
// ---------------------------------------------------------------------------
module axi_lite_read_slave
    import axi_lite_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int unsigned           NUM_REGS   = 16,
    parameter int unsigned           RD_LATENCY = 1
) (
    input  logic                        clk,
    input  logic                        reset,

    input  logic                        s_axi_arvalid,
    output logic                        s_axi_arready,
    input  logic [ADDR_WIDTH-1:0]       s_axi_araddr,

    output logic                        s_axi_rvalid,
    input  logic                        s_axi_rready,
    output logic [31:0]                 s_axi_rdata,
    output logic [1:0]                  s_axi_rresp,

    output logic                        rd_en,
    output logic [$clog2(NUM_REGS)-1:0] rd_index,
    input  logic [31:0]                 rd_data,

    output logic [7:0]                  err_count
);

    localparam int unsigned IDX_W = $clog2(NUM_REGS);

    // The window is checked on an address one bit wider than the bus so that
    // addresses below BASE_ADDR wrap to a huge offset and fail the single
    // upper-bound compare, and BASE_ADDR + window size cannot overflow.
    localparam logic [ADDR_WIDTH:0] WINDOW_BYTES = (ADDR_WIDTH+1)'(4 * NUM_REGS);
    localparam logic [3:0]          LAT          = 4'(RD_LATENCY);

    state_t              stateQ,  stateD;
    logic   [3:0]        cntQ,    cntD;
    logic   [31:0]       rdataQ,  rdataD;
    logic   [1:0]        rrespQ,  rrespD;
    logic   [7:0]        errCntQ, errCntD;

    logic                arHandshake;
    logic                rHandshake;
    logic [ADDR_WIDTH:0] offsetExt;
    logic [1:0]          decodeResp;

    // Both channel-ready/valid flags are forced low while reset is high,
    // since a synchronous reset leaves the old state visible for that cycle.
    assign s_axi_arready = (stateQ == IDLE) && !reset;
    assign s_axi_rvalid  = (stateQ == RESP) && !reset;
    assign arHandshake   = s_axi_arvalid && s_axi_arready;
    assign rHandshake    = s_axi_rvalid && s_axi_rready;

    // Address decode: misalignment wins over the range check.
    always_comb begin
        offsetExt  = {1'b0, s_axi_araddr} - {1'b0, BASE_ADDR};
        decodeResp = RSP_OKAY;
        if (s_axi_araddr[1:0] != 2'b00) begin
            decodeResp = RSP_SLVERR;
        end else if (offsetExt >= WINDOW_BYTES) begin
            decodeResp = RSP_DECERR;
        end
    end

    // Backend strobe is issued in the AR handshake cycle itself.
    assign rd_index = IDX_W'(offsetExt >> 2);
    assign rd_en    = arHandshake && (decodeResp == RSP_OKAY);

    // Next-state logic. Error responses skip WAIT entirely and carry zero
    // data; OKAY reads count the backend latency and capture rd_data on the
    // last counted cycle only.
    always_comb begin
        stateD  = stateQ;
        cntD    = cntQ;
        rdataD  = rdataQ;
        rrespD  = rrespQ;
        errCntD = errCntQ;
        case (stateQ)
            IDLE: begin
                if (arHandshake) begin
                    rrespD = decodeResp;
                    if (decodeResp == RSP_OKAY) begin
                        cntD   = 4'd1;
                        stateD = WAIT;
                    end else begin
                        rdataD = '0;
                        stateD = RESP;
                    end
                end
            end
            WAIT: begin
                if (cntQ == LAT) begin
                    rdataD = rd_data;
                    stateD = RESP;
                end else begin
                    cntD = cntQ + 4'd1;
                end
            end
            RESP: begin
                if (rHandshake) begin
                    stateD = IDLE;
                    if ((rrespQ != RSP_OKAY) && (errCntQ != 8'hFF)) begin
                        errCntD = errCntQ + 8'd1;
                    end
                end
            end
            default: begin
                stateD = IDLE;
            end
        endcase
    end

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ  <= IDLE;
            cntQ    <= '0;
            rdataQ  <= '0;
            rrespQ  <= RSP_OKAY;
            errCntQ <= '0;
        end else begin
            stateQ  <= stateD;
            cntQ    <= cntD;
            rdataQ  <= rdataD;
            rrespQ  <= rrespD;
            errCntQ <= errCntD;
        end
    end

    assign s_axi_rdata = rdataQ;
    assign s_axi_rresp = rrespQ;
    assign err_count   = errCntQ;

endmodule

// File: tb/tb_axi_lite_read_slave.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_read_slave
// Self-checking bench for axi_lite_read_slave (BASE 0x4000_0000, 16 words,
// backend latency 2). Each read is driven cycle by cycle; expected response
// codes, indices, timing and the error counter come from a transaction-level
// model of the address map kept in this file.
// ---------------------------------------------------------------------------
module tb_axi_lite_read_slave;
    import axi_lite_pkg::*;

    localparam logic [31:0] BASE  = 32'h4000_0000;
    localparam int          NREGS = 16;
    localparam int          LAT   = 2;

    logic        clk;
    logic        reset;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_araddr;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        rd_en;
    logic [3:0]  rd_index;
    logic [31:0] rd_data;
    logic [7:0]  err_count;

    int checks   = 0;
    int errors   = 0;
    int errModel = 0;

    axi_lite_read_slave #(
        .ADDR_WIDTH (32),
        .BASE_ADDR  (BASE),
        .NUM_REGS   (NREGS),
        .RD_LATENCY (LAT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .rd_en         (rd_en),
        .rd_index      (rd_index),
        .rd_data       (rd_data),
        .err_count     (err_count)
    );

    // 100 MHz-style free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something wedges the stimulus process
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Reference decode straight from the address map rules
    function automatic logic [1:0] expectedResp(input logic [31:0] addr);
        longint a;
        longint lo;
        a  = longint'({32'd0, addr});
        lo = longint'({32'd0, BASE});
        if (addr % 4 != 0) return RSP_SLVERR;
        if (a >= lo && a < lo + 4 * NREGS) return RSP_OKAY;
        return RSP_DECERR;
    endfunction

    // Advance to just after the next rising edge, where inputs are driven
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Noise on inputs the DUT is supposed to ignore in the current cycle
    task automatic junkInputs(input bit holdArvalid);
        s_axi_arvalid = holdArvalid ? 1'b1 : 1'($urandom_range(0, 1));
        s_axi_araddr  = $urandom;
        rd_data       = $urandom;
    endtask

    // Idle cycles: DUT must sit ready with no response and no backend strobe
    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            nextCycle();
            s_axi_arvalid = 1'b0;
            s_axi_rready  = 1'($urandom_range(0, 1));
            rd_data       = $urandom;
            #1;
            checkOutput("idle_arready", 32'(s_axi_arready), 32'd1);
            checkOutput("idle_rvalid",  32'(s_axi_rvalid),  32'd0);
            checkOutput("idle_rd_en",   32'(rd_en),         32'd0);
        end
    endtask

    // One complete read: AR handshake, backend latency, R phase with rready
    // held low for holdLow cycles. Ends in the R-handshake cycle so a
    // following call issues its AR in the very next cycle.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                                 input int holdLow, input bit holdArvalid);
        logic [1:0]  resp;
        logic [31:0] expData;
        logic [31:0] idx;
        resp    = expectedResp(addr);
        idx     = (addr - BASE) >> 2;
        expData = (resp == RSP_OKAY) ? data : 32'd0;

        nextCycle();
        s_axi_arvalid = 1'b1;
        s_axi_araddr  = addr;
        s_axi_rready  = 1'b1;
        rd_data       = $urandom;
        #1;
        checkOutput("err_count",  32'(err_count),     32'(errModel));
        checkOutput("ar_arready", 32'(s_axi_arready), 32'd1);
        checkOutput("ar_rvalid",  32'(s_axi_rvalid),  32'd0);
        checkOutput("ar_rd_en",   32'(rd_en),         32'(resp == RSP_OKAY));
        if (resp == RSP_OKAY) begin
            checkOutput("ar_rd_index", 32'(rd_index), idx);
        end

        if (resp == RSP_OKAY) begin
            for (int k = 1; k <= LAT; k++) begin
                nextCycle();
                junkInputs(holdArvalid);
                s_axi_rready = 1'($urandom_range(0, 1));
                if (k == LAT) rd_data = data;
                #1;
                checkOutput("wait_rvalid",  32'(s_axi_rvalid),  32'd0);
                checkOutput("wait_arready", 32'(s_axi_arready), 32'd0);
                checkOutput("wait_rd_en",   32'(rd_en),         32'd0);
            end
        end

        for (int h = 0; h <= holdLow; h++) begin
            nextCycle();
            junkInputs(holdArvalid);
            s_axi_rready = (h == holdLow);
            #1;
            checkOutput("resp_rvalid",  32'(s_axi_rvalid),  32'd1);
            checkOutput("resp_rdata",   s_axi_rdata,        expData);
            checkOutput("resp_rresp",   32'(s_axi_rresp),   32'(resp));
            checkOutput("resp_arready", 32'(s_axi_arready), 32'd0);
            checkOutput("resp_rd_en",   32'(rd_en),         32'd0);
            checkOutput("resp_not_exokay", 32'(s_axi_rresp == RSP_EXOKAY), 32'd0);
        end

        if (resp != RSP_OKAY && errModel < 255) errModel++;
    endtask

    // Reset while the backend read is in flight: the read is dropped and the
    // data arriving in its capture slot must not surface anywhere.
    task automatic resetInWait();
        nextCycle();
        s_axi_arvalid = 1'b1;
        s_axi_araddr  = BASE + 32'h8;
        s_axi_rready  = 1'b1;
        rd_data       = $urandom;
        #1;
        checkOutput("rstw_rd_en", 32'(rd_en), 32'd1);

        nextCycle();
        s_axi_arvalid = 1'b0;
        reset         = 1'b1;
        rd_data       = $urandom;
        #1;
        checkOutput("rstw_arready_in_rst", 32'(s_axi_arready), 32'd0);
        checkOutput("rstw_rvalid_in_rst",  32'(s_axi_rvalid),  32'd0);
        checkOutput("rstw_rd_en_in_rst",   32'(rd_en),         32'd0);

        nextCycle();
        reset   = 1'b0;
        rd_data = 32'hCAFE_F00D;
        #1;
        errModel = 0;
        checkOutput("rstw_arready_after", 32'(s_axi_arready), 32'd1);
        checkOutput("rstw_rvalid_after",  32'(s_axi_rvalid),  32'd0);
        checkOutput("rstw_rdata_after",   s_axi_rdata,        32'd0);
        checkOutput("rstw_err_count",     32'(err_count),     32'd0);

        idleCycles(3);
        checkOutput("rstw_rdata_late", s_axi_rdata, 32'd0);
    endtask

    // Random address drawn from in-window, misaligned and out-of-window pools
    function automatic logic [31:0] randomAddr();
        case ($urandom_range(0, 3))
            0, 1:    return BASE + 32'(4 * $urandom_range(0, NREGS - 1));
            2:       return BASE + 32'(4 * $urandom_range(0, NREGS - 1) + $urandom_range(1, 3));
            default: return $urandom_range(0, 1) != 0
                            ? BASE + 32'(4 * NREGS + 4 * $urandom_range(0, 15))
                            : ($urandom & 32'hFFFF_FFFC);
        endcase
    endfunction

    // Main sequence
    initial begin
        reset         = 1'b1;
        s_axi_arvalid = 1'b1;
        s_axi_araddr  = BASE;
        s_axi_rready  = 1'b1;
        rd_data       = 32'd0;

        // Reset held: nothing may be accepted or strobed even with arvalid up
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            #1;
            checkOutput("rst_arready", 32'(s_axi_arready), 32'd0);
            checkOutput("rst_rvalid",  32'(s_axi_rvalid),  32'd0);
            checkOutput("rst_rd_en",   32'(rd_en),         32'd0);
        end
        nextCycle();
        reset         = 1'b0;
        s_axi_arvalid = 1'b0;
        #1;
        checkOutput("post_rst_arready",   32'(s_axi_arready), 32'd1);
        checkOutput("post_rst_err_count", 32'(err_count),     32'd0);
        checkOutput("post_rst_rresp",     32'(s_axi_rresp),   32'(RSP_OKAY));
        checkOutput("post_rst_rdata",     s_axi_rdata,        32'd0);

        // Directed reads, including window edges and decode priority
        applyStimulus(BASE + 32'h08, 32'hDEAD_BEEF, 0, 1'b0);
        idleCycles(1);
        applyStimulus(BASE + 32'h40, $urandom, 0, 1'b0);
        applyStimulus(BASE + 32'h06, $urandom, 0, 1'b0);
        applyStimulus(BASE + 32'h00, $urandom, 0, 1'b0);
        applyStimulus(BASE + 32'h3C, $urandom, 0, 1'b0);
        applyStimulus(BASE - 32'h04, $urandom, 0, 1'b0);
        applyStimulus(BASE + 32'h3F, $urandom, 0, 1'b0);
        applyStimulus(32'hFFFF_FFFC, $urandom, 0, 1'b0);
        applyStimulus(32'h0000_0001, $urandom, 0, 1'b0);

        // Back-pressure on R, then back-to-back reads with arvalid held high
        applyStimulus(BASE + 32'h0C, $urandom, 5, 1'b1);
        applyStimulus(BASE + 32'h44, $urandom, 5, 1'b1);
        applyStimulus(BASE + 32'h04, $urandom, 0, 1'b1);
        applyStimulus(BASE + 32'h14, $urandom, 0, 1'b1);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            applyStimulus(randomAddr(), $urandom, $urandom_range(0, 3),
                          1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) != 0) idleCycles($urandom_range(1, 2));
        end

        resetInWait();
        applyStimulus(BASE + 32'h08, $urandom, 0, 1'b0);

        // Error counter saturation
        for (int n = 0; n < 300; n++) begin
            applyStimulus(BASE + 32'h06, $urandom, 0, 1'b0);
        end
        nextCycle();
        s_axi_arvalid = 1'b0;
        #1;
        checkOutput("err_count_sat", 32'(err_count), 32'(errModel));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_lite_read_slave.md
AXI_LITE_READ_SLAVE -- requirements
Module: axi_lite_read_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width of s_axi_araddr.
REQ-002 SHALL have parameter BASE_ADDR, default 0, byte address of register index 0, word aligned.
REQ-003 SHALL have parameter NUM_REGS, default 16, number of 32-bit words decoded, power of two, 2..256.
REQ-004 SHALL have parameter RD_LATENCY, default 1, cycles from rd_en to valid rd_data, range 1..15.
REQ-005 SHALL have port clk  in  1  clock, all state on rising edge.
REQ-006 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-007 SHALL have ports s_axi_arvalid in 1 and s_axi_arready out 1, AR handshake.
REQ-008 SHALL have port s_axi_araddr  in  ADDR_WIDTH  read byte address.
REQ-009 SHALL have ports s_axi_rvalid out 1 and s_axi_rready in 1, R handshake.
REQ-010 SHALL have ports s_axi_rdata out 32 and s_axi_rresp out 2, read data and response.
REQ-011 SHALL have port rd_en  out  1  single-cycle backend read strobe.
REQ-012 SHALL have port rd_index  out  $clog2(NUM_REGS)  backend word index.
REQ-013 SHALL have port rd_data  in  32  backend data, valid exactly RD_LATENCY cycles after rd_en.
REQ-014 SHALL have port err_count  out  8  saturating count of SLVERR/DECERR responses.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP; one transaction outstanding at most.
REQ-016 SHALL drive s_axi_arready=1 only in IDLE; AR handshake = arvalid && arready.
REQ-017 SHALL decode on handshake: addr[1:0]!=0 -> SLVERR (2'b10); addr outside [BASE_ADDR, BASE_ADDR+4*NUM_REGS) -> DECERR (2'b11); else OKAY (2'b00); misalignment checked first.
REQ-018 SHALL, for OKAY on handshake cycle T, assert rd_en combinationally in cycle T with rd_index=(addr-BASE_ADDR)>>2, and enter WAIT.
REQ-019 SHALL never assert rd_en for SLVERR/DECERR; such handshakes go IDLE->RESP directly with s_axi_rdata=0.
REQ-020 SHALL in WAIT count RD_LATENCY cycles with a 4-bit counter, capture rd_data at the edge ending cycle T+RD_LATENCY, enter RESP; s_axi_rvalid first high at T+RD_LATENCY+1 (OKAY) or T+1 (error).
REQ-021 SHALL drive s_axi_rvalid=1 throughout RESP with s_axi_rdata/s_axi_rresp held stable from registers until rvalid && rready.
REQ-022 SHALL on R handshake return to IDLE; next AR accepted no earlier than the following cycle.
REQ-023 SHALL ignore rd_data outside its capture cycle and ignore arvalid outside IDLE.
REQ-024 SHALL increment err_count once per error response at its R handshake, saturating at 255.

Reset
REQ-025 SHALL on reset enter IDLE, clear counter, rdata=0, rresp=OKAY, err_count=0.
REQ-026 SHALL while reset is high drive s_axi_arready=0, s_axi_rvalid=0, rd_en=0.
REQ-027 SHALL on reset mid-WAIT or mid-RESP abandon the transaction: no response issued, late rd_data ignored, s_axi_arready=1 in first cycle after reset deasserts.

Structure
REQ-028 SHALL take RSP_OKAY/RSP_EXOKAY/RSP_SLVERR/RSP_DECERR and the FSM state enum from shared package axi_lite_pkg.
REQ-029 SHALL be a single module, no sub-modules; decode is inline combinational logic.

Verification (BASE_ADDR=0x4000_0000, NUM_REGS=16, RD_LATENCY=2, rready high unless stated)
REQ-030 SHALL cover: AR 0x4000_0008 at T -> rd_en at T, rd_index=2; rd_data=0xDEADBEEF at T+2 -> rvalid at T+3, rdata=0xDEADBEEF, rresp=00.
REQ-031 SHALL cover: AR 0x4000_0040 -> no rd_en, rvalid at T+1, rdata=0, rresp=11, err_count=1.
REQ-032 SHALL cover: AR 0x4000_0006 -> no rd_en, rresp=10; repeated 300 times -> err_count=255.
REQ-033 SHALL cover: rready held low 5 cycles in RESP -> rvalid, rdata, rresp stable, arready=0, extra arvalid ignored.
REQ-034 SHALL cover: reset asserted in WAIT -> no rvalid, rd_data at capture slot ignored, arready=1 cycle after reset release.
REQ-035 SHALL cover: arvalid held high, two OKAY reads -> second AR accepted cycle after first R handshake; no overlap of rd_en.
